// File: rtl/ram_scan_pkg.sv
// RAM scan engine shared types.
// Pattern modes, FSM states and checkerboard constants.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR_LO  = 2'd0,
    MODE_ADDR_XOR = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_MARCH    = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD     = 3'd2,
    S_WR_INV = 3'd3,
    S_RD_INV = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  // truncated to the data width at the point of use
  localparam logic [63:0] CHECK_EVEN = {32{2'b01}};
  localparam logic [63:0] CHECK_ODD  = {32{2'b10}};

endpackage

// File: rtl/ram_scan_if.sv
// Memory request bus between the scan engine and the RAM port.
// Request is held until acked; read data is valid in the ack cycle.
interface ram_scan_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ram_scan_pattern.sv
// Combinational test pattern generator.
// Shared by the write data path and the read compare path.
module ram_scan_pattern
  import ram_scan_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  mode_t         mode,
  input  logic          inv,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  // high byte source: top DW bits, or whatever lies above the low byte
  localparam int SH = (AW >= 2 * DW) ? (AW - DW) : DW;

  logic [DW-1:0] lo;
  logic [DW-1:0] hi;

  always_comb begin
    lo = addr[DW-1:0];
    hi = '0;
    for (int i = 0; i < DW; i++) begin
      if (SH + i < AW) hi[i] = addr[SH+i];
    end
  end

  always_comb begin
    data = lo;
    unique case (mode)
      MODE_ADDR_LO:  data = lo;
      MODE_ADDR_XOR: data = lo ^ hi;
      MODE_CHECKER:  data = addr[0] ? CHECK_ODD[DW-1:0]
                                    : CHECK_EVEN[DW-1:0];
      MODE_MARCH:    data = inv ? ~lo : lo;
      default:       data = lo;
    endcase
  end

endmodule

// File: rtl/ram_scan_engine.sv
// Self-timed RAM fill-and-verify scanner with optional march pass,
// saturating error count and first-failure capture.
module ram_scan_engine
  import ram_scan_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  stop_on_fail,
  input  logic [ADDR_WIDTH-1:0] addr_first,
  input  logic [ADDR_WIDTH-1:0] addr_last,
  ram_scan_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  range_err,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act
);

  state_t                state_q, state_d, next_phase;
  mode_t                 mode_q, mode_d;
  logic                  stop_q, stop_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic [DATA_WIDTH-1:0] fe_q, fe_d;
  logic [DATA_WIDTH-1:0] fx_q, fx_d;
  logic                  pass_q, pass_d;
  logic                  range_q, range_d;

  logic                  req, rd_phase, inv_phase;
  logic                  access, mismatch;
  logic [DATA_WIDTH-1:0] pat;

  ram_scan_pattern #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_pat (
    .mode(mode_q),
    .inv (inv_phase),
    .addr(addr_q),
    .data(pat)
  );

  assign req = (state_q == S_WR) || (state_q == S_RD) ||
               (state_q == S_WR_INV) || (state_q == S_RD_INV);
  assign rd_phase  = (state_q == S_RD) || (state_q == S_RD_INV);
  assign inv_phase = (state_q == S_WR_INV) || (state_q == S_RD_INV);
  assign access    = req && mem.mem_ack;
  assign mismatch  = rd_phase && (mem.mem_rdata != pat);

  assign mem.mem_req   = req;
  assign mem.mem_we    = (state_q == S_WR) || (state_q == S_WR_INV);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = pat;

  assign busy      = req;
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign range_err = range_q;
  assign err_count = err_q;
  assign fail_addr = fa_q;
  assign fail_exp  = fe_q;
  assign fail_act  = fx_q;

  always_comb begin
    next_phase = S_FIN;
    unique case (state_q)
      S_WR:     next_phase = S_RD;
      S_RD:     next_phase = (mode_q == MODE_MARCH) ? S_WR_INV : S_FIN;
      S_WR_INV: next_phase = S_RD_INV;
      default:  next_phase = S_FIN;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    first_d = first_q;
    last_d  = last_q;
    addr_d  = addr_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fe_d    = fe_q;
    fx_d    = fx_q;
    pass_d  = pass_q;
    range_d = range_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          stop_d  = stop_on_fail;
          first_d = addr_first;
          last_d  = addr_last;
          addr_d  = addr_first;
          err_d   = '0;
          fa_d    = '0;
          fe_d    = '0;
          fx_d    = '0;
          pass_d  = 1'b0;
          range_d = (addr_last < addr_first);
          state_d = range_d ? S_FIN : S_WR;
        end
      end
      S_WR, S_RD, S_WR_INV, S_RD_INV: begin
        if (access) begin
          if (mismatch) begin
            if (err_q == '0) begin
              fa_d = addr_q;
              fe_d = pat;
              fx_d = mem.mem_rdata;
            end
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          // terminate on the last address, never by wrap-around
          if (mismatch && stop_q) begin
            state_d = S_FIN;
          end else if (addr_q == last_q) begin
            addr_d  = first_q;
            state_d = next_phase;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FIN && state_q != S_FIN) begin
      pass_d = (err_d == '0) && !range_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ADDR_LO;
      stop_q  <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fe_q    <= '0;
      fx_q    <= '0;
      pass_q  <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      first_q <= first_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fe_q    <= fe_d;
      fx_q    <= fx_d;
      pass_q  <= pass_d;
      range_q <= range_d;
    end
  end

endmodule

// File: tb/tb_ram_scan_engine.sv
// Bench for ram_scan_engine: memory model with read fault injection,
// access-sequence scoreboard and end-of-scan result checks.
module tb_ram_scan_engine;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          stop_on_fail;
  logic [AW-1:0] addr_first;
  logic [AW-1:0] addr_last;
  logic          busy, done, pass, range_err;
  logic [EW-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;

  ram_scan_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_scan_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ERR_WIDTH (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .stop_on_fail(stop_on_fail),
    .addr_first  (addr_first),
    .addr_last   (addr_last),
    .mem         (bus.master),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .range_err   (range_err),
    .err_count   (err_count),
    .fail_addr   (fail_addr),
    .fail_exp    (fail_exp),
    .fail_act    (fail_act)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } acc_t;

  int   errors = 0;
  int   checks = 0;
  acc_t expq[$];
  int   exp_n, exp_err, exp_fa, exp_fe, exp_fx;
  bit   exp_pass, exp_range;
  int   n_acc;
  int   dcyc;

  logic [7:0] mem_arr [0:65535];
  int         f_addr = -1;
  logic [7:0] f_xor = 8'h00;
  bit         f_all = 1'b0;
  bit         ack_rand = 1'b0;
  logic [7:0] rd_v;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] faulty(input int a, input logic [7:0] v);
    if (f_all || a == f_addr) return v ^ f_xor;
    return v;
  endfunction

  // pattern definitions from the data sheet, in plain arithmetic
  function automatic logic [7:0] pat(input int m, input bit inv, input int a);
    int lo, hi;
    lo = a % 256;
    hi = (a / 256) % 256;
    case (m)
      0:       return 8'(lo);
      1:       return 8'(lo ^ hi);
      2:       return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return inv ? 8'(255 - lo) : 8'(lo);
    endcase
  endfunction

  // memory: stores writes, applies the injected fault on reads
  always_comb begin
    rd_v = mem_arr[bus.mem_addr];
    if (f_all || int'(bus.mem_addr) == f_addr) rd_v = rd_v ^ f_xor;
    bus.mem_rdata = rd_v;
  end

  always @(posedge clk) begin
    #2;
    bus.mem_ack = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic build(input int m, input int first, input int last,
                       input bit stop);
    int         nph;
    logic [7:0] d, act;
    acc_t       e;
    expq.delete();
    exp_err = 0; exp_fa = 0; exp_fe = 0; exp_fx = 0;
    exp_range = 1'b0; exp_pass = 1'b0;
    if (last < first) begin
      exp_range = 1'b1;
      exp_n = 0;
      return;
    end
    nph = (m == 3) ? 4 : 2;
    for (int ph = 0; ph < nph; ph++) begin
      for (int a = first; a <= last; a++) begin
        d = pat(m, ph >= 2, a);
        e.we = (ph % 2 == 0);
        e.a  = a[15:0];
        e.d  = d;
        expq.push_back(e);
        if (ph % 2 == 1) begin
          act = faulty(a, d);
          if (act != d) begin
            if (exp_err == 0) begin
              exp_fa = a; exp_fe = d; exp_fx = act;
            end
            if (exp_err < 255) exp_err++;
            if (stop) begin
              exp_n = expq.size();
              return;
            end
          end
        end
      end
    end
    exp_pass = (exp_err == 0);
    exp_n = expq.size();
  endtask

  // every cycle with a pending request must match the scoreboard head
  always @(negedge clk) begin
    acc_t h;
    if (!reset && bus.mem_req) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_access: got addr 0x%0h expected no request",
                 bus.mem_addr);
      end else begin
        h = expq[0];
        chk("access",
            {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00},
            {h.we, h.a, h.we ? h.d : 8'h00});
        if (bus.mem_ack) begin
          if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
          void'(expq.pop_front());
        end
      end
      if (bus.mem_ack) n_acc++;
    end
  end

  task automatic kick(input int m, input int first, input int last,
                      input bit stop, input bit ar);
    build(m, first, last, stop);
    ack_rand = ar;
    n_acc = 0;
    @(negedge clk);
    mode = 2'(m);
    addr_first = 16'(first);
    addr_last = 16'(last);
    stop_on_fail = stop;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_wait(input string tag, input bit timed);
    dcyc = -1;
    for (int k = 1; k <= 20000; k++) begin
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clk);
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done", tag);
      return;
    end
    chk({tag, "_n_acc"}, n_acc, exp_n);
    if (timed) chk({tag, "_done_cycle"}, dcyc, exp_n + 1);
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_range_err"}, range_err, exp_range);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_queue_left"}, expq.size(), 0);
    if (exp_err > 0) begin
      chk({tag, "_fail_addr"}, fail_addr, exp_fa);
      chk({tag, "_fail_exp"}, fail_exp, exp_fe);
      chk({tag, "_fail_act"}, fail_act, exp_fx);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_pass_sticky"}, pass, exp_pass);
  endtask

  initial begin
    int wait_ok;
    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    stop_on_fail = 1'b0;
    addr_first = '0;
    addr_last = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, pass, range_err, err_count, bus.mem_req}, 0);
    chk("reset_fail_regs", {fail_addr, fail_exp, fail_act}, 0);
    reset = 1'b0;

    // T1 ADDR_LO full page, ack tied high
    kick(0, 16'h0000, 16'h00FF, 1'b0, 1'b0);
    finish_wait("t1", 1'b1);
    chk("t1_n_lit", n_acc, 512);
    chk("t1_cycle_lit", dcyc, 513);
    chk("t1_pass_lit", pass, 1);

    // T2 MARCH with bit3 corrupted on reads of 0x0042
    f_addr = 16'h0042; f_xor = 8'h08;
    kick(3, 16'h0000, 16'h00FF, 1'b0, 1'b0);
    finish_wait("t2", 1'b1);
    chk("t2_err_lit", err_count, 2);
    chk("t2_fa_lit", fail_addr, 16'h0042);
    chk("t2_fe_lit", fail_exp, 8'h42);
    chk("t2_fx_lit", fail_act, 8'h4A);
    chk("t2_pass_lit", pass, 0);

    // saturation: every read fails, random stalls
    f_addr = -1; f_all = 1'b1; f_xor = 8'h80;
    kick(0, 16'h0000, 16'h012C, 1'b0, 1'b1);
    finish_wait("sat", 1'b0);
    chk("sat_err_lit", err_count, 255);
    chk("sat_fx_lit", fail_act, 8'h80);

    // T3 stop on first failure, CHECKER
    f_all = 1'b0; f_addr = 16'h0010; f_xor = 8'h01;
    kick(2, 16'h0000, 16'h001F, 1'b1, 1'b0);
    finish_wait("t3", 1'b1);
    chk("t3_n_lit", n_acc, 49);
    chk("t3_cycle_lit", dcyc, 50);
    chk("t3_err_lit", err_count, 1);
    chk("t3_fx_lit", fail_act, 8'h54);

    // T4 top-of-space window must not wrap
    f_addr = -1; f_xor = 8'h00;
    kick(1, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0);
    finish_wait("t4", 1'b1);
    chk("t4_n_lit", n_acc, 4);
    chk("t4_pass_lit", pass, 1);

    // T5 inverted window
    kick(0, 16'h0020, 16'h001F, 1'b0, 1'b0);
    finish_wait("t5", 1'b1);
    chk("t5_range_lit", range_err, 1);
    chk("t5_n_lit", n_acc, 0);
    chk("t5_cycle_lit", dcyc, 1);

    // T6 stalls, reset during the read pass, then a clean rescan
    kick(3, 16'h0300, 16'h033F, 1'b0, 1'b1);
    wait_ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (bus.mem_req && !bus.mem_we) begin
        wait_ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_reached_rd", wait_ok, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    chk("t6_req_after_reset", bus.mem_req, 0);
    chk("t6_busy_after_reset", busy, 0);
    chk("t6_err_after_reset", err_count, 0);
    repeat (4) @(negedge clk);
    chk("t6_quiet", {bus.mem_req, busy, done}, 0);
    kick(1, 16'h1230, 16'h12A0, 1'b0, 1'b1);
    finish_wait("t6", 1'b0);
    chk("t6_pass_lit", pass, 1);
    chk("t6_range_clear", range_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
